// File: rtl/cpu_pkg.sv
// Shared definitions for the Full_CPU_HDL control path: state codes, opcodes
// and the decoded-instruction record passed from instr_decode to the sequencer.
package cpu_pkg;

    localparam int OPW_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Per-opcode enables consumed in EXEC (and DECODE for hlt).
    typedef struct packed {
        logic rd;     // mem_rd level during EXEC
        logic wr;     // mem_wr strobe on the EXEC step
        logic jmp;    // pc_load strobe on the EXEC step
        logic sub;    // ALU subtract select
        logic to_wb;  // EXEC continues to WB instead of FETCH
        logic hlt;    // DECODE goes to HALT
    } dec_t;

endpackage

// File: rtl/instr_cycle_ctrl_if.sv
// Bus between timing_generator/datapath and instr_cycle_ctrl.
// The retired port exists only when INSTR_CYCLE_CTRL_RETIRE_CNT_EN is defined.
interface instr_cycle_ctrl_if #(
    parameter int OPW  = 4,
    parameter int CNTW = 16
);
    logic           start;
    logic           step;
    logic           clk_s0;
    logic           clk_s1;
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           E;
    logic           mem_rd;
    logic           mem_wr;
    logic           ir_load;
    logic           pc_inc;
    logic           pc_load;
    logic           acc_load;
    logic           alu_sub;
    logic           halted;
    logic [2:0]     state;
`ifdef INSTR_CYCLE_CTRL_RETIRE_CNT_EN
    logic [CNTW-1:0] retired;
`else
    wire [CNTW-1:0] unused_cntw = '0;
`endif

    modport master (
        output start, step, clk_s0, clk_s1, opcode, zero,
        input  E, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load,
               alu_sub, halted, state
`ifdef INSTR_CYCLE_CTRL_RETIRE_CNT_EN
               , retired
`endif
    );

    modport slave (
        input  start, step, clk_s0, clk_s1, opcode, zero,
        output E, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load,
               alu_sub, halted, state
`ifdef INSTR_CYCLE_CTRL_RETIRE_CNT_EN
               , retired
`endif
    );

endinterface

// File: rtl/instr_cycle_ctrl_decode.sv
// instr_decode: purely combinational opcode/zero -> exec-class enables.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int OPW = OPW_DEFAULT
) (
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output dec_t           dec
);

    // NOTE: every output of a combinational block gets a default first, otherwise
    // unlisted opcodes would leave dec unassigned and infer a latch.
    always_comb begin
        dec = '0;
        case (opcode)
            OPW'(OP_LDA): begin dec.rd = 1'b1; dec.to_wb = 1'b1; end
            OPW'(OP_STA): dec.wr = 1'b1;
            OPW'(OP_ADD): begin dec.rd = 1'b1; dec.to_wb = 1'b1; end
            OPW'(OP_SUB): begin dec.rd = 1'b1; dec.to_wb = 1'b1; dec.sub = 1'b1; end
            OPW'(OP_JMP): dec.jmp = 1'b1;
            OPW'(OP_JZ):  dec.jmp = zero;
            OPW'(OP_HLT): dec.hlt = 1'b1;
            default:      dec = '0;
        endcase
    end

endmodule

// File: rtl/instr_cycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driven by timing_generator's step.
// Optional retired-instruction counter: define INSTR_CYCLE_CTRL_RETIRE_CNT_EN.
module instr_cycle_ctrl
    import cpu_pkg::*;
#(
    parameter int OPW  = OPW_DEFAULT,
    parameter int CNTW = 16
) (
    input logic               clk,
    input logic               rst,
    instr_cycle_ctrl_if.slave bus
);

    state_t state_q, state_d;
    logic   start_q;
    logic   sub_q;
    dec_t   dec;
    logic   fire;
    logic   retire;
    logic   e, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load, alu_sub, halted;

    // The phase-0 qualifier carries no decision for this block.
    wire unused_ok = &{1'b0, bus.clk_s0};

    instr_decode #(.OPW(OPW)) u_decode (
        .opcode (bus.opcode),
        .zero   (bus.zero),
        .dec    (dec)
    );

    assign fire = bus.step & bus.clk_s1;

    always_comb begin
        state_d  = state_q;
        e        = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        acc_load = 1'b0;
        alu_sub  = 1'b0;
        halted   = 1'b0;
        retire   = 1'b0;
        case (state_q)
            IDLE: if (bus.start) state_d = FETCH;
            FETCH: begin
                e      = 1'b1;
                mem_rd = 1'b1;
                if (bus.step) begin
                    state_d = DECODE;
                    ir_load = fire;
                    pc_inc  = fire;
                end
            end
            DECODE: begin
                e = 1'b1;
                if (bus.step) state_d = dec.hlt ? HALT : EXEC;
            end
            EXEC: begin
                e       = 1'b1;
                mem_rd  = dec.rd;
                alu_sub = dec.sub;
                if (bus.step) begin
                    state_d = dec.to_wb ? WB : FETCH;
                    mem_wr  = fire & dec.wr;
                    pc_load = fire & dec.jmp;
                    retire  = ~dec.to_wb;
                end
            end
            WB: begin
                e       = 1'b1;
                alu_sub = sub_q;
                if (bus.step) begin
                    state_d  = FETCH;
                    acc_load = fire;
                    retire   = 1'b1;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (bus.start && !start_q) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            if (state_q == EXEC && bus.step) sub_q <= dec.sub;
        end
    end

    // Reset suppresses every output in the same cycle so no partial write escapes.
    assign bus.E        = e        & ~rst;
    assign bus.mem_rd   = mem_rd   & ~rst;
    assign bus.mem_wr   = mem_wr   & ~rst;
    assign bus.ir_load  = ir_load  & ~rst;
    assign bus.pc_inc   = pc_inc   & ~rst;
    assign bus.pc_load  = pc_load  & ~rst;
    assign bus.acc_load = acc_load & ~rst;
    assign bus.alu_sub  = alu_sub  & ~rst;
    assign bus.halted   = halted   & ~rst;
    assign bus.state    = state_q;

`ifdef INSTR_CYCLE_CTRL_RETIRE_CNT_EN
    logic [CNTW-1:0] retired_q;

    always_ff @(posedge clk) begin
        if (rst)         retired_q <= '0;
        else if (retire) retired_q <= retired_q + 1'b1;
    end

    assign bus.retired = retired_q;
`else
    wire unused_retire = retire;
    wire [CNTW-1:0] unused_cntw = '0;
`endif

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Directed bench for instr_cycle_ctrl; retired checks build only with
// INSTR_CYCLE_CTRL_RETIRE_CNT_EN defined (counter width 2).
module tb_instr_cycle_ctrl;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   n_ir, n_pci, n_pcl, n_acc, n_wr, n_sub;

    always #5 clk = ~clk;

    instr_cycle_ctrl_if #(.OPW(4), .CNTW(2)) bus ();

    instr_cycle_ctrl #(.OPW(4), .CNTW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic clear_counts();
        n_ir = 0; n_pci = 0; n_pcl = 0; n_acc = 0; n_wr = 0; n_sub = 0;
    endtask

    // One clk: drive step/phase, sample outputs mid-cycle, then cross the edge.
    task automatic clk_once(input logic st, input logic s1);
        bus.step   = st;
        bus.clk_s1 = s1;
        bus.clk_s0 = ~s1;
        #1;
        if (bus.ir_load)  n_ir++;
        if (bus.pc_inc)   n_pci++;
        if (bus.pc_load)  n_pcl++;
        if (bus.acc_load) n_acc++;
        if (bus.mem_wr)   n_wr++;
        if (bus.alu_sub)  n_sub++;
        @(posedge clk);
        #1;
        bus.step   = 1'b0;
        bus.clk_s1 = 1'b0;
    endtask

    // One machine cycle: a quiet clk followed by the step clk.
    task automatic mcycle(input logic s1);
        clk_once(1'b0, 1'b0);
        clk_once(1'b1, s1);
    endtask

    task automatic go_fetch();
        rst = 1'b1;
        clk_once(1'b0, 1'b0);
        rst = 1'b0;
        bus.start = 1'b1;
        clk_once(1'b0, 1'b0);
        bus.start = 1'b0;
        clear_counts();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        clk_once(1'b0, 1'b0);
        clk_once(1'b1, 1'b1);
        total++;
        if (bus.state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        total++;
        if ({bus.E, bus.mem_rd, bus.alu_sub, bus.halted} !== 4'b0) begin
            bad++; $display("FAIL reset_levels: got %b want 0000", {bus.E, bus.mem_rd, bus.alu_sub, bus.halted});
        end
        bus.start = 1'b1;
        clk_once(1'b0, 1'b0);
        total++;
        if (bus.state !== 3'd0) begin bad++; $display("FAIL rst_beats_start: got %0d want 0", bus.state); end
        rst = 1'b0;
        clear_counts();
        clk_once(1'b0, 1'b0);
        bus.start = 1'b0;
        total++;
        if (bus.state !== 3'd1 || bus.E !== 1'b1) begin
            bad++; $display("FAIL start_to_fetch: got state=%0d E=%b want 1/1", bus.state, bus.E);
        end
        total++;
        if (bus.mem_rd !== 1'b1) begin bad++; $display("FAIL fetch_mem_rd: got %b want 1", bus.mem_rd); end
        clk_once(1'b0, 1'b0);
        clk_once(1'b1, 1'b0);
        total++;
        if (n_ir !== 0 || bus.state !== 3'd2) begin
            bad++; $display("FAIL fetch_no_s1: got ir=%0d state=%0d want 0/2", n_ir, bus.state);
        end
        clk_once(1'b1, 1'b1);
        total++;
        if (n_ir !== 0 || n_pci !== 0) begin
            bad++; $display("FAIL strobe_wrong_state: got ir=%0d pc_inc=%0d want 0/0", n_ir, n_pci);
        end
    endtask

    task automatic test_program();
        go_fetch();
        bus.opcode = OP_LDA;
        mcycle(1'b1);
        mcycle(1'b1);
        total++;
        if (bus.state !== 3'd3 || bus.mem_rd !== 1'b1 || bus.alu_sub !== 1'b0) begin
            bad++; $display("FAIL lda_exec: got state=%0d rd=%b sub=%b want 3/1/0", bus.state, bus.mem_rd, bus.alu_sub);
        end
        mcycle(1'b1);
        mcycle(1'b1);
        total++;
        if (n_ir !== 1 || n_pci !== 1 || n_acc !== 1 || bus.state !== 3'd1) begin
            bad++; $display("FAIL lda_done: got ir=%0d pci=%0d acc=%0d state=%0d want 1/1/1/1", n_ir, n_pci, n_acc, bus.state);
        end
        bus.opcode = OP_ADD;
        repeat (4) mcycle(1'b1);
        total++;
        if (n_ir !== 2 || n_pci !== 2 || n_acc !== 2 || n_sub !== 0) begin
            bad++; $display("FAIL add_done: got ir=%0d pci=%0d acc=%0d sub=%0d want 2/2/2/0", n_ir, n_pci, n_acc, n_sub);
        end
        bus.opcode = OP_HLT;
        mcycle(1'b1);
        mcycle(1'b1);
        total++;
        if (bus.state !== 3'd5 || bus.halted !== 1'b1 || bus.E !== 1'b0 || n_acc !== 2 || n_ir !== 3) begin
            bad++; $display("FAIL hlt_done: got state=%0d halted=%b E=%b acc=%0d ir=%0d want 5/1/0/2/3",
                            bus.state, bus.halted, bus.E, n_acc, n_ir);
        end
    endtask

    task automatic test_sub_hold();
        go_fetch();
        bus.opcode = OP_SUB;
        mcycle(1'b1);
        mcycle(1'b1);
        total++;
        if (bus.alu_sub !== 1'b1 || bus.mem_rd !== 1'b1) begin
            bad++; $display("FAIL sub_exec: got sub=%b rd=%b want 1/1", bus.alu_sub, bus.mem_rd);
        end
        mcycle(1'b1);
        bus.opcode = OP_NOP;
        #1;
        total++;
        if (bus.state !== 3'd4 || bus.alu_sub !== 1'b1 || bus.mem_rd !== 1'b0) begin
            bad++; $display("FAIL sub_wb_hold: got state=%0d sub=%b rd=%b want 4/1/0", bus.state, bus.alu_sub, bus.mem_rd);
        end
        mcycle(1'b1);
        total++;
        if (bus.alu_sub !== 1'b0 || n_acc !== 1 || bus.state !== 3'd1) begin
            bad++; $display("FAIL sub_done: got sub=%b acc=%0d state=%0d want 0/1/1", bus.alu_sub, n_acc, bus.state);
        end
    endtask

    task automatic test_jumps();
        go_fetch();
        bus.opcode = OP_JZ;
        bus.zero   = 1'b0;
        repeat (3) mcycle(1'b1);
        total++;
        if (n_pcl !== 0 || bus.state !== 3'd1) begin
            bad++; $display("FAIL jz_not_taken: got pc_load=%0d state=%0d want 0/1", n_pcl, bus.state);
        end
        bus.zero = 1'b1;
        repeat (3) mcycle(1'b1);
        total++;
        if (n_pcl !== 1 || bus.state !== 3'd1) begin
            bad++; $display("FAIL jz_taken: got pc_load=%0d state=%0d want 1/1", n_pcl, bus.state);
        end
        bus.zero   = 1'b0;
        bus.opcode = OP_JMP;
        repeat (3) mcycle(1'b1);
        total++;
        if (n_pcl !== 2 || n_wr !== 0) begin
            bad++; $display("FAIL jmp: got pc_load=%0d mem_wr=%0d want 2/0", n_pcl, n_wr);
        end
    endtask

    task automatic test_no_s1_store();
        go_fetch();
        bus.opcode = OP_STA;
        mcycle(1'b1);
        mcycle(1'b1);
        mcycle(1'b0);
        total++;
        if (bus.state !== 3'd1 || n_wr !== 0) begin
            bad++; $display("FAIL sta_no_s1: got state=%0d mem_wr=%0d want 1/0", bus.state, n_wr);
        end
        repeat (3) mcycle(1'b1);
        total++;
        if (bus.state !== 3'd1 || n_wr !== 1) begin
            bad++; $display("FAIL sta_s1: got state=%0d mem_wr=%0d want 1/1", bus.state, n_wr);
        end
    endtask

    task automatic test_rst_in_wb();
        go_fetch();
        bus.opcode = OP_NOP;
        repeat (3) mcycle(1'b1);
        bus.opcode = OP_LDA;
        repeat (3) mcycle(1'b1);
`ifdef INSTR_CYCLE_CTRL_RETIRE_CNT_EN
        total++;
        if (bus.retired !== 2'd1) begin bad++; $display("FAIL retired_pre_rst: got %0d want 1", bus.retired); end
`endif
        total++;
        if (bus.state !== 3'd4) begin bad++; $display("FAIL reach_wb: got %0d want 4", bus.state); end
        rst = 1'b1;
        clk_once(1'b1, 1'b1);
        rst = 1'b0;
        total++;
        if (n_acc !== 0 || bus.state !== 3'd0) begin
            bad++; $display("FAIL rst_in_wb: got acc=%0d state=%0d want 0/0", n_acc, bus.state);
        end
`ifdef INSTR_CYCLE_CTRL_RETIRE_CNT_EN
        total++;
        if (bus.retired !== 2'd0) begin bad++; $display("FAIL retired_rst: got %0d want 0", bus.retired); end
`endif
    endtask

`ifdef INSTR_CYCLE_CTRL_RETIRE_CNT_EN
    task automatic test_retire_cnt();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        go_fetch();
        bus.opcode = OP_NOP;
        for (int i = 0; i < 5; i++) begin
            repeat (3) mcycle(1'b1);
            total++;
            if (bus.retired !== exp_cnt[i]) begin
                bad++; $display("FAIL retired_nop%0d: got %0d want %0d", i, bus.retired, exp_cnt[i]);
            end
        end
        bus.opcode = OP_HLT;
        mcycle(1'b1);
        mcycle(1'b1);
        repeat (3) clk_once(1'b1, 1'b1);
        total++;
        if (bus.retired !== 2'd1 || bus.state !== 3'd5) begin
            bad++; $display("FAIL retired_hlt: got cnt=%0d state=%0d want 1/5", bus.retired, bus.state);
        end
    endtask
`endif

    task automatic test_halt_restart();
        go_fetch();
        bus.opcode = OP_HLT;
        bus.start  = 1'b1;
        mcycle(1'b1);
        mcycle(1'b1);
        repeat (3) clk_once(1'b1, 1'b1);
        total++;
        if (bus.state !== 3'd5 || bus.halted !== 1'b1 || bus.E !== 1'b0) begin
            bad++; $display("FAIL halt_held_start: got state=%0d halted=%b E=%b want 5/1/0", bus.state, bus.halted, bus.E);
        end
        bus.start = 1'b0;
        clk_once(1'b0, 1'b0);
        total++;
        if (bus.state !== 3'd5) begin bad++; $display("FAIL halt_start_low: got %0d want 5", bus.state); end
        bus.start = 1'b1;
        clk_once(1'b0, 1'b0);
        bus.start = 1'b0;
        total++;
        if (bus.state !== 3'd1 || bus.halted !== 1'b0 || bus.E !== 1'b1) begin
            bad++; $display("FAIL halt_restart: got state=%0d halted=%b E=%b want 1/0/1", bus.state, bus.halted, bus.E);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.step   = 1'b0;
        bus.clk_s0 = 1'b0;
        bus.clk_s1 = 1'b0;
        bus.opcode = OP_NOP;
        bus.zero   = 1'b0;
        clear_counts();
        test_reset();
        test_program();
        test_sub_hold();
        test_jumps();
        test_no_s1_store();
        test_rst_in_wb();
`ifdef INSTR_CYCLE_CTRL_RETIRE_CNT_EN
        test_retire_cnt();
`endif
        test_halt_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
